// File: rtl/seg_scan_if.sv
// seg_scan_if: load handshake and display outputs of seg_scan_sched.
// The slave modport is the scheduler; the master modport is the producer
// that also watches the display pins.
//
// Handshake: load_data moves from producer to scheduler on a rising clk
// edge where load_valid and load_ready are both high. The producer holds
// load_valid and load_data steady until that edge. load_ready does not
// depend on load_valid in the same cycle.
interface seg_scan_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;
    logic        frame_done;
    // Debug view of the scan FSM: dbg_drive=1 in DRIVE, dbg_idx = digit index
    logic        dbg_drive;
    logic [1:0]  dbg_idx;

    modport master (
        output load_valid, load_data,
        input  load_ready, seg, dp, dig, frame_done, dbg_drive, dbg_idx
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, seg, dp, dig, frame_done, dbg_drive, dbg_idx
    );
endinterface

// File: rtl/seg_scan_sched.sv
// seg_scan_sched: four-digit multiplexed 7-segment scan scheduler.
// Each digit gets DEAD all-off cycles followed by DWELL driven cycles.
// New values are double-buffered (pending -> active) and are promoted
// only at a frame boundary, so a frame never shows a mix of two values.
// Optional feature: define SEG_LZB_EN for leading-zero blanking.
//
// With DEAD=0, the post-reset BLANK state still occupies one cycle
// because the outputs are registered and reset to the blank pattern; from
// then on every DRIVE runs straight into the next.
module seg_scan_sched #(
    parameter int DWELL = 1000,
    parameter int DEAD  = 16
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam int MAXC     = (DWELL > DEAD) ? DWELL : DEAD;
    localparam int CW       = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int DEAD_M1  = (DEAD > 0) ? DEAD - 1 : 0;
    localparam int DWELL_M1 = (DWELL > 0) ? DWELL - 1 : 0;
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_M1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_M1);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   pending_q, pending_d;
    logic          pending_full_q, pending_full_d;
    logic [3:0]    dig_q, dig_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;

    logic          last_blank;
    logic          last_drive;
    logic          frame_end;
    logic          xfer;

    // BCD to active-low {a,b,c,d,e,f,g}; non-BCD nibbles are blank
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h01;
            4'd1:    s = 7'h4F;
            4'd2:    s = 7'h12;
            4'd3:    s = 7'h06;
            4'd4:    s = 7'h4C;
            4'd5:    s = 7'h24;
            4'd6:    s = 7'h60;
            4'd7:    s = 7'h0F;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h0C;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Segment pattern for digit i of value v (leading zeros optionally blank)
    function automatic logic [6:0] digit_seg(input logic [15:0] v,
                                             input logic [1:0]  i);
        logic [3:0] nib;
        logic [6:0] s;
        nib = v[{i, 2'b00} +: 4];
        s   = decode(nib);
`ifdef SEG_LZB_EN
        begin
            logic lead;
            case (i)
                2'd1:    lead = (v[15:4]  == 12'h000);
                2'd2:    lead = (v[15:8]  == 8'h00);
                2'd3:    lead = (v[15:12] == 4'h0);
                default: lead = 1'b0;
            endcase
            if (lead) s = 7'h7F;
        end
`endif
        return s;
    endfunction

    // State, counter and buffer registers; reset blanks the display at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BLANK;
            idx_q          <= 2'd0;
            cnt_q          <= '0;
            active_q       <= 16'hFFFF;
            pending_q      <= 16'h0000;
            pending_full_q <= 1'b0;
            dig_q          <= 4'b0000;
            seg_q          <= 7'h7F;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            dig_q          <= dig_d;
            seg_q          <= seg_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Scan FSM next state: BLANK for DEAD cycles, DRIVE for DWELL cycles
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + 1'b1;
        last_blank = (state_q == BLANK) && ((DEAD == 0) || (cnt_q == DEAD_LAST));
        last_drive = (state_q == DRIVE) && (cnt_q == DWELL_LAST);
        frame_end  = last_drive && (idx_q == 2'd3);
        case (state_q)
            BLANK: begin
                if (last_blank) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (last_drive) begin
                    state_d = (DEAD == 0) ? DRIVE : BLANK;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = BLANK;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Double buffer: promote pending only at the frame boundary edge
    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        xfer           = bus.load_valid && !pending_full_q;
        if (frame_end && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (xfer) begin
            pending_d      = bus.load_data;
            pending_full_d = 1'b1;
        end
    end

    // Display outputs computed from next state so dig/seg/frame_done flop together
    always_comb begin
        dig_d        = 4'b0000;
        seg_d        = 7'h7F;
        frame_done_d = 1'b0;
        if (state_d == DRIVE) begin
            dig_d        = 4'b0001 << idx_d;
            seg_d        = digit_seg(active_d, idx_d);
            frame_done_d = (idx_d == 2'd3) && (cnt_d == DWELL_LAST);
        end
    end

    assign bus.load_ready = !pending_full_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.dig        = dig_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_drive  = (state_q == DRIVE);
    assign bus.dbg_idx    = idx_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: self-checking bench for seg_scan_sched (DWELL=4, DEAD=2).
// Reference model: frame position arithmetic (t mod 24) plus an abstract
// pending/active buffer, checked against the DUT each sampled cycle.
module tb_seg_scan_sched;

    localparam int DWELL = 4;
    localparam int DEAD  = 2;
    localparam int SLOT  = DEAD + DWELL;
    localparam int FRAME = 4 * SLOT;

    logic clk;
    logic rst;
    seg_scan_if dut_if ();

    seg_scan_sched #(.DWELL(DWELL), .DEAD(DEAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    int total;
    int bad;

    // Reference model state
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    logic        m_pf;

    logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h60, 7'h0F, 7'h00, 7'h0C};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int pos();
        return m_t % FRAME;
    endfunction

    function automatic logic [3:0] exp_dig();
        int p;
        p = pos();
        if ((p % SLOT) < DEAD) return 4'b0000;
        return 4'(1 << (p / SLOT));
    endfunction

    function automatic logic [6:0] exp_seg();
        int p;
        int d;
        int nib;
        int upper;
        p = pos();
        if ((p % SLOT) < DEAD) return 7'h7F;
        d     = p / SLOT;
        upper = int'(m_active) >> (4 * d);
        nib   = upper % 16;
`ifdef SEG_LZB_EN
        if (d > 0 && upper == 0) return 7'h7F;
`endif
        if (nib > 9) return 7'h7F;
        return seg_tab[nib];
    endfunction

    function automatic logic exp_fd();
        return pos() == FRAME - 1;
    endfunction

    task automatic model_reset();
        m_t      = 0;
        m_active = 16'hFFFF;
        m_pend   = 16'h0000;
        m_pf     = 1'b0;
    endtask

    // One rising edge: update model with the inputs seen at that edge, then sample point
    task automatic tick();
        logic xfer;
        @(posedge clk);
        xfer = dut_if.load_valid && !m_pf;
        if (pos() == FRAME - 1 && m_pf) begin
            m_active = m_pend;
            m_pf     = 1'b0;
        end
        if (xfer) begin
            m_pend = dut_if.load_data;
            m_pf   = 1'b1;
        end
        m_t++;
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (dut_if.load_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (dut_if.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_timeout got=%b exp=1", name, dut_if.load_ready);
        end
    endtask

    task automatic drive_load(input logic [15:0] data);
        dut_if.load_valid = 1'b1;
        dut_if.load_data  = data;
        tick();
        dut_if.load_valid = 1'b0;
        dut_if.load_data  = $urandom;
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (pos() != p && n < FRAME) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        dut_if.load_valid = 1'b0;
        dut_if.load_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_if.dig !== 4'b0000 || dut_if.seg !== 7'h7F) begin
            bad++;
            $display("FAIL reset_display got=%b/%h exp=0000/7f", dut_if.dig, dut_if.seg);
        end
        total++;
        if (dut_if.dp !== 1'b1 || dut_if.frame_done !== 1'b0 || dut_if.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags dp=%b fd=%b rdy=%b exp=1/0/1",
                     dut_if.dp, dut_if.frame_done, dut_if.load_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_idle_frame();
        int fd_seen;
        fd_seen = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            total++;
            if (dut_if.dig !== exp_dig() || dut_if.seg !== exp_seg()) begin
                bad++;
                $display("FAIL idle_out t=%0d got=%b/%h exp=%b/%h",
                         m_t, dut_if.dig, dut_if.seg, exp_dig(), exp_seg());
            end
            total++;
            if (dut_if.frame_done !== exp_fd()) begin
                bad++;
                $display("FAIL idle_fd t=%0d got=%b exp=%b", m_t, dut_if.frame_done, exp_fd());
            end
            if (dut_if.frame_done === 1'b1 && fd_seen < 0) fd_seen = m_t;
            tick();
        end
        total++;
        if (fd_seen != 23) begin
            bad++;
            $display("FAIL idle_first_fd got=%0d exp=23", fd_seen);
        end
    endtask

    task automatic test_load_mid_frame();
        logic [6:0] exp_s [4] = '{7'h4C, 7'h06, 7'h12, 7'h4F};
        wait_pos(10);
        wait_ready("mid");
        drive_load(16'h1234);
        // Rest of this frame still shows the old value
        while (pos() != 0) begin
            total++;
            if (dut_if.dig !== exp_dig() || dut_if.seg !== exp_seg()) begin
                bad++;
                $display("FAIL mid_hold t=%0d got=%b/%h exp=%b/%h",
                         m_t, dut_if.dig, dut_if.seg, exp_dig(), exp_seg());
            end
            tick();
        end
        for (int d = 0; d < 4; d++) begin
            wait_pos(d * SLOT + DEAD);
            total++;
            if (dut_if.dig !== 4'(1 << d) || dut_if.seg !== exp_s[d]) begin
                bad++;
                $display("FAIL mid_show d=%0d got=%b/%h exp=%b/%h",
                         d, dut_if.dig, dut_if.seg, 4'(1 << d), exp_s[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int acc_pos;
        logic acc;
        wait_ready("b2b");
        dut_if.load_valid = 1'b1;
        dut_if.load_data  = 16'h1111;
        tick();
        total++;
        if (dut_if.load_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_low got=%b exp=0", dut_if.load_ready);
        end
        dut_if.load_data = 16'h2222;
        n = 0;
        acc = 1'b0;
        acc_pos = -1;
        while (!acc && n < 3 * FRAME) begin
            acc = (dut_if.load_ready === 1'b1);
            if (acc) acc_pos = pos();
            total++;
            if (dut_if.load_ready !== !m_pf) begin
                bad++;
                $display("FAIL b2b_ready t=%0d got=%b exp=%b", m_t, dut_if.load_ready, !m_pf);
            end
            tick();
            n++;
        end
        dut_if.load_valid = 1'b0;
        total++;
        if (acc_pos != 0) begin
            bad++;
            $display("FAIL b2b_accept_pos got=%0d exp=0", acc_pos);
        end
        wait_pos(DEAD);
        total++;
        if (dut_if.dig !== 4'b0001 || dut_if.seg !== 7'h4F) begin
            bad++;
            $display("FAIL b2b_first got=%b/%h exp=0001/4f", dut_if.dig, dut_if.seg);
        end
        tick();
        wait_pos(DEAD);
        total++;
        if (dut_if.dig !== 4'b0001 || dut_if.seg !== 7'h12) begin
            bad++;
            $display("FAIL b2b_second got=%b/%h exp=0001/12", dut_if.dig, dut_if.seg);
        end
    endtask

    task automatic test_pattern(input string name, input logic [15:0] data,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_s [4];
        int n;
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
        wait_ready(name);
        drive_load(data);
        n = 0;
        while (!(m_active == data && pos() == 0) && n < 3 * FRAME) begin
            tick();
            n++;
        end
        for (int d = 0; d < 4; d++) begin
            wait_pos(d * SLOT + DEAD + 1);
            total++;
            if (dut_if.dig !== 4'(1 << d) || dut_if.seg !== exp_s[d]) begin
                bad++;
                $display("FAIL %s_d%0d got=%b/%h exp=%b/%h",
                         name, d, dut_if.dig, dut_if.seg, 4'(1 << d), exp_s[d]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            dut_if.load_valid = ($urandom_range(0, 3) == 0);
            dut_if.load_data  = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                            : 16'($urandom_range(0, 999));
            tick();
            total++;
            if (dut_if.dig !== exp_dig() || dut_if.seg !== exp_seg()) begin
                bad++;
                $display("FAIL rand_out t=%0d got=%b/%h exp=%b/%h act=%h",
                         m_t, dut_if.dig, dut_if.seg, exp_dig(), exp_seg(), m_active);
            end
            total++;
            if (dut_if.frame_done !== exp_fd() || dut_if.load_ready !== !m_pf) begin
                bad++;
                $display("FAIL rand_ctl t=%0d fd=%b rdy=%b exp=%b/%b",
                         m_t, dut_if.frame_done, dut_if.load_ready, exp_fd(), !m_pf);
            end
        end
        dut_if.load_valid = 1'b0;
    endtask

    task automatic test_reset_mid_drive();
        wait_pos(2 * SLOT + DEAD + 1);
        total++;
        if (dut_if.dig !== 4'b0100) begin
            bad++;
            $display("FAIL rmd_pre got=%b exp=0100", dut_if.dig);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (dut_if.dig !== 4'b0000 || dut_if.seg !== 7'h7F) begin
            bad++;
            $display("FAIL rmd_async got=%b/%h exp=0000/7f", dut_if.dig, dut_if.seg);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_if.dig !== 4'b0000 || dut_if.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmd_t0 got=%b rdy=%b exp=0000/1", dut_if.dig, dut_if.load_ready);
        end
        tick();
        tick();
        total++;
        if (dut_if.dig !== 4'b0001 || dut_if.seg !== 7'h7F) begin
            bad++;
            $display("FAIL rmd_first_drive got=%b/%h exp=0001/7f", dut_if.dig, dut_if.seg);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        test_reset();
        test_idle_frame();
        test_load_mid_frame();
        test_back_to_back();
`ifdef SEG_LZB_EN
        test_pattern("a9", 16'h00A9, 7'h0C, 7'h7F, 7'h7F, 7'h7F);
        test_pattern("42", 16'h0042, 7'h12, 7'h4C, 7'h7F, 7'h7F);
`else
        test_pattern("a9", 16'h00A9, 7'h0C, 7'h7F, 7'h01, 7'h01);
        test_pattern("42", 16'h0042, 7'h12, 7'h4C, 7'h01, 7'h01);
`endif
        test_pattern("8076", 16'h8076, 7'h60, 7'h0F, 7'h01, 7'h00);
        test_random();
        test_reset_mid_drive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
